// File: rtl/operand_fetch_16.sv
// Operand fetch stage for the bitwise logic units.
// Holds the general-purpose register file (register 0 hard-wired to zero),
// accepts writeback results, and returns operand pairs through one registered
// output stage with valid/ready flow control and write-to-read forwarding.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   we, waddr, wdata    register writeback
//   req_valid/req_ready operand read request handshake (req_ready is combinational)
//   ra_addr, rb_addr    source registers for op_a / op_b
//   op_valid/op_ready   operand pair handshake towards the consumer
//   op_a, op_b          registered operand pair
//   fetch_count         wrapping count of delivered operand pairs
module operand_fetch_16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [15:0]      fetch_count
);

  localparam int unsigned CW = 16;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             accept;
  logic             deliver;

  // No skid buffer: a new request fits only if the output stage is empty or draining.
  assign req_ready = !op_valid || op_ready;
  assign accept    = req_valid && req_ready;
  assign deliver   = op_valid && op_ready;

  // Source read with zero register and same-cycle writeback forwarding.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (ra_addr != '0) begin
      if (we && (waddr == ra_addr)) rd_a = wdata;
      else                          rd_a = regs[ra_addr];
    end
    if (rb_addr != '0) begin
      if (we && (waddr == rb_addr)) rd_b = wdata;
      else                          rd_b = regs[rb_addr];
    end
  end

  // Register file; index 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Output stage: operands are captured at acceptance and held through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= rd_a;
      op_b     <= rd_b;
    end else if (deliver) begin
      op_valid <= 1'b0;
    end
  end

  // Delivered-pair counter, modulo 2^16.
  always_ff @(posedge clk) begin
    if (reset)        fetch_count <= '0;
    else if (deliver) fetch_count <= fetch_count + CW'(1);
  end

endmodule

// File: tb/tb_operand_fetch_16.sv
// Directed self-checking bench for operand_fetch_16.
module tb_operand_fetch_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] mdl [8];

  always #5 clk = ~clk;

  operand_fetch_16 dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
    if (a != 3'd0) mdl[a] = d;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    req_valid = 1'b0; ra_addr = '0; rb_addr = '0; op_ready = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    chk("rst_op_valid", 16'(op_valid), 16'h0);
    chk("rst_op_a", op_a, 16'h0000);
    chk("rst_op_b", op_b, 16'h0000);
    chk("rst_count", fetch_count, 16'h0000);

    // Basic read
    wr(3'd3, 16'hA5A5);
    wr(3'd5, 16'h0FF0);
    req_valid = 1'b1; ra_addr = 3'd3; rb_addr = 3'd5; op_ready = 1'b1;
    #1 chk("idle_req_ready", 16'(req_ready), 16'h1);
    tick();
    req_valid = 1'b0;
    chk("basic_valid", 16'(op_valid), 16'h1);
    chk("basic_a", op_a, 16'hA5A5);
    chk("basic_b", op_b, 16'h0FF0);
    chk("basic_count_pre", fetch_count, 16'h0000);
    tick();
    chk("basic_count", fetch_count, 16'h0001);
    chk("basic_drain", 16'(op_valid), 16'h0);

    // Forwarding of a same-cycle write
    we = 1'b1; waddr = 3'd2; wdata = 16'h1234; mdl[2] = 16'h1234;
    req_valid = 1'b1; ra_addr = 3'd2; rb_addr = 3'd0;
    tick();
    we = 1'b0; req_valid = 1'b0;
    chk("fwd_a", op_a, 16'h1234);
    chk("fwd_b", op_b, 16'h0000);
    tick();
    chk("fwd_count", fetch_count, 16'h0002);

    // Write to R0 is ignored
    wr(3'd0, 16'hFFFF);
    req_valid = 1'b1; ra_addr = 3'd0; rb_addr = 3'd0;
    tick();
    req_valid = 1'b0;
    chk("r0_a", op_a, 16'h0000);
    chk("r0_b", op_b, 16'h0000);
    tick();
    chk("r0_count", fetch_count, 16'h0003);

    // Stall: held pair unaffected by writes
    op_ready = 1'b0;
    req_valid = 1'b1; ra_addr = 3'd3; rb_addr = 3'd3;
    tick();
    req_valid = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 16'h0001; mdl[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 16'(op_valid), 16'h1);
      chk("stall_a", op_a, 16'hA5A5);
      chk("stall_b", op_b, 16'hA5A5);
      chk("stall_req_ready", 16'(req_ready), 16'h0);
      chk("stall_count", fetch_count, 16'h0003);
    end
    we = 1'b0;
    op_ready = 1'b1;
    tick();
    chk("release_count", fetch_count, 16'h0004);
    chk("release_valid", 16'(op_valid), 16'h0);
    req_valid = 1'b1; ra_addr = 3'd3; rb_addr = 3'd0;
    tick();
    req_valid = 1'b0;
    chk("post_stall_a", op_a, 16'h0001);
    tick();
    chk("post_stall_count", fetch_count, 16'h0005);

    // Back-to-back with rotating addresses
    wr(3'd1, 16'hF00F);
    wr(3'd4, 16'h4444);
    wr(3'd6, 16'h6666);
    wr(3'd7, 16'h7777);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; ra_addr = 3'(i); rb_addr = 3'(7 - i);
      tick();
      chk("b2b_valid", 16'(op_valid), 16'h1);
      chk("b2b_a", op_a, mdl[i]);
      chk("b2b_b", op_b, mdl[7 - i]);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_count", fetch_count, 16'h000D);
    chk("b2b_drain", 16'(op_valid), 16'h0);

    // Reset mid-transfer; write in reset cycle is discarded
    op_ready = 1'b0;
    req_valid = 1'b1; ra_addr = 3'd5; rb_addr = 3'd7;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_valid", 16'(op_valid), 16'h1);
    reset = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; req_valid = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    chk("mid_rst_valid", 16'(op_valid), 16'h0);
    chk("mid_rst_a", op_a, 16'h0000);
    chk("mid_rst_b", op_b, 16'h0000);
    chk("mid_rst_count", fetch_count, 16'h0000);
    op_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      req_valid = 1'b1; ra_addr = 3'(i); rb_addr = 3'(i);
      tick();
      chk("cleared_a", op_a, 16'h0000);
      chk("cleared_b", op_b, 16'h0000);
    end
    req_valid = 1'b0;
    tick();
    chk("cleared_count", fetch_count, 16'h0007);

    // Counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 1'b1; op_ready = 1'b1; ra_addr = 3'd0; rb_addr = 3'd0;
    repeat (65535) tick();
    req_valid = 1'b0;
    tick();
    chk("count_ffff", fetch_count, 16'hFFFF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("count_wrap", fetch_count, 16'h0000);
    chk("wrap_drain", 16'(op_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_16.md
Name: operand_fetch_16

Overview:
- 16-bit operand source for the datapath's bitwise logic units (AND/OR/etc.): holds the general-purpose register file and delivers operand pairs (op_a, op_b) to the consuming unit over a valid/ready handshake.
- Accepts writeback results into the register file.
- Serves operand-read requests through a single registered output stage with write-to-read forwarding.

Parameters:
- WIDTH, 16, data width of registers and operands.
- NREGS, 8, number of registers; register 0 reads as zero.
- AW, 3, register address width (log2 NREGS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  register write enable.
- waddr  input  AW  write register index.
- wdata  input  WIDTH  write data.
- req_valid  input  1  operand read request valid.
- req_ready  output  1  block can accept a request this cycle.
- ra_addr  input  AW  source register for op_a.
- rb_addr  input  AW  source register for op_b.
- op_valid  output  1  op_a/op_b hold a valid operand pair.
- op_ready  input  1  consumer takes the operand pair this cycle.
- op_a  output  WIDTH  operand A.
- op_b  output  WIDTH  operand B.
- fetch_count  output  16  number of operand pairs delivered (op_valid && op_ready), wrapping.

Behaviour:
- Reset (sync, active-high, sampled on the clk rising edge):
  - All registers clear to 0.
  - op_valid=0, op_a=0, op_b=0, fetch_count=0.
  - Requests and writes in the reset cycle are discarded.
  - Reset mid-transfer drops any held operand pair with no delivery counted.
- Write:
  - If we=1 and waddr!=0, reg[waddr] <= wdata at the clock edge.
  - A write to index 0 is ignored; reg 0 always reads 0.
- Ready rule:
  - req_ready = !op_valid || op_ready, combinational; there is no skid buffer.
- Accept:
  - A request is accepted when req_valid && req_ready.
  - On accept, at the next edge op_valid <= 1 and op_a/op_b are loaded with the read values.
  - Latency: 1 cycle from request acceptance to op_valid.
- Read value for each source s:
  - 0 if s==0.
  - Else wdata if we && waddr==s in the same cycle (write forwarding).
  - Else reg[s].
- ra_addr == rb_addr is legal; both operands get the same value.
- Hold:
  - While op_valid && !op_ready, op_a/op_b/op_valid hold stable.
  - Register writes during the stall do not alter the held pair; the pair was captured at acceptance.
- Delivery:
  - On op_valid && op_ready, fetch_count increments by 1; 16'hFFFF wraps to 0.
  - If a new request is accepted in the same cycle, op_valid stays 1 and new operands load: back-to-back, one pair per cycle.
  - Otherwise op_valid <= 0.
- op_ready while op_valid=0 has no effect; no count.
- Control inputs are ignored while reset is high.
- Arithmetic: no arithmetic on data; fetch_count uses modulo-2^16 increment.

Test Plan:
- Reset then write R3=16'hA5A5 and R5=16'h0FF0; request ra=3, rb=5 with op_ready=1 -> next cycle op_valid=1, op_a=A5A5, op_b=0FF0, fetch_count 0->1.
- Same cycle: we=1, waddr=2, wdata=16'h1234, plus request ra=2, rb=0 -> op_a=1234 (forwarded), op_b=0000; a later write of 16'hFFFF to R0 followed by a read of R0 -> 0000.
- Stall: accept ra=3, hold op_ready=0 for 4 cycles while writing R3=16'h0001 -> op_a stays A5A5, req_ready=0, count unchanged; release -> count+1, a new read of R3 returns 0001.
- Back-to-back: req_valid=1 and op_ready=1 for 8 cycles with rotating addresses -> op_valid continuous after the first cycle, 8 pairs delivered, each matching the model, count +8.
- Reset asserted while op_valid=1 and op_ready=0 -> next cycle op_valid=0, op_a=op_b=0, all registers read 0, count=0.
- Preload fetch_count to FFFF via 65535 deliveries, then one more delivery -> count=0000.
